// File: rtl/vw_chunk_buffer_if.sv
// Handshake bundle for vw_chunk_buffer: element write port plus chunked read port.
// The master drives writes and read requests; the slave is the buffer itself.
interface vw_chunk_buffer_if #(
    parameter int VecLength   = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8
);
    localparam int Chunks = VecLength / WorkingRegs;
    localparam int IdxW   = $clog2(Chunks) + 1;

    logic                           wr_en;
    logic signed [NBits-1:0]        wr_data;
    logic                           wr_ready;
    logic                           overflow;
    logic                           out_data_ready;
    logic [WorkingRegs*NBits-1:0]   out_data;
    logic                           req_chunk_in;
    logic                           req_chunk_ptr_rst;
    logic                           rd_release;
    logic [IdxW-1:0]                rd_chunk_idx;

    modport master (
        output wr_en, wr_data, req_chunk_in, req_chunk_ptr_rst, rd_release,
        input  wr_ready, overflow, out_data_ready, out_data, rd_chunk_idx
    );

    modport slave (
        input  wr_en, wr_data, req_chunk_in, req_chunk_ptr_rst, rd_release,
        output wr_ready, overflow, out_data_ready, out_data, rd_chunk_idx
    );
endinterface

// File: rtl/vw_chunk_buffer.sv
// Ping-pong vector buffer: producer fills one bank element by element while the
// consumer re-reads the other bank in WorkingRegs-wide chunks.
module vw_chunk_buffer #(
    parameter int VecLength   = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    vw_chunk_buffer_if.slave     bus
);
    localparam int Chunks = VecLength / WorkingRegs;
    localparam int CIW    = $clog2(Chunks) + 1;
    localparam int WIW    = $clog2(VecLength);

    logic signed [NBits-1:0]      mem [2][VecLength];
    logic [WIW-1:0]               wr_idx;
    logic                         wr_bank;
    logic                         rd_bank;
    logic [1:0]                   full_count;
    logic [1:0]                   full_count_next;
    logic [CIW-1:0]               rd_chunk;
    logic                         overflow_q;
    logic                         wr_fire;
    logic                         wr_done;
    logic                         rd_active;
    logic                         rel;
    logic [WorkingRegs*NBits-1:0] out_data_c;

    assign wr_fire   = bus.wr_en && bus.wr_ready;
    assign wr_done   = wr_fire && (wr_idx == WIW'(VecLength - 1));
    assign rd_active = (full_count != 2'd0);
    assign rel       = rd_active && bus.rd_release;

    assign bus.wr_ready       = (full_count < 2'd2);
    assign bus.overflow       = overflow_q;
    assign bus.out_data_ready = rd_active;
    assign bus.out_data       = out_data_c;
    assign bus.rd_chunk_idx   = rd_chunk;

    // A completed write and a release in the same cycle cancel out.
    always_comb begin
        full_count_next = full_count;
        case ({wr_done, rel})
            2'b10:   full_count_next = full_count + 2'd1;
            2'b01:   full_count_next = full_count - 2'd1;
            default: full_count_next = full_count;
        endcase
    end

    always_comb begin
        out_data_c = '0;
        if (rd_active) begin
            for (int i = 0; i < WorkingRegs; i++) begin
                out_data_c[i*NBits +: NBits] =
                    mem[rd_bank][WIW'(int'(rd_chunk) * WorkingRegs + i)];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem[wr_bank][wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full_count <= 2'd0;
            rd_chunk   <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_count <= full_count_next;
            if (bus.wr_en && !bus.wr_ready) begin
                overflow_q <= 1'b1;
            end
            if (wr_done) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else if (wr_fire) begin
                wr_idx <= wr_idx + WIW'(1);
            end
            if (rel) begin
                rd_chunk <= '0;
                rd_bank  <= ~rd_bank;
            end else if (rd_active && bus.req_chunk_ptr_rst) begin
                rd_chunk <= '0;
            end else if (rd_active && bus.req_chunk_in) begin
                if (rd_chunk == CIW'(Chunks - 1)) begin
                    rd_chunk <= '0;
                end else begin
                    rd_chunk <= rd_chunk + CIW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vw_chunk_buffer.sv
// Directed self-checking bench for vw_chunk_buffer (VecLength=16, WorkingRegs=4, NBits=8).
module tb_vw_chunk_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vw_chunk_buffer_if #(.VecLength(16), .WorkingRegs(4), .NBits(8)) bus ();

    vw_chunk_buffer #(.VecLength(16), .WorkingRegs(4), .NBits(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected chunk with lane i holding element value base+i (lane 0 in the low byte).
    function automatic logic [31:0] exp_chunk(input int base);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*8 +: 8] = 8'(base + i);
        end
        return v;
    endfunction

    task automatic write_run(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(first + i);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_req();
        bus.req_chunk_in = 1'b1;
        tick();
        bus.req_chunk_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        check_output({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        check_output({tag, "_odr"}, 32'(bus.out_data_ready), 32'd0);
        check_output({tag, "_out_data"}, bus.out_data, 32'd0);
        check_output({tag, "_idx"}, 32'(bus.rd_chunk_idx), 32'd0);
    endtask

    initial begin
        bus.wr_en             = 1'b0;
        bus.wr_data           = '0;
        bus.req_chunk_in      = 1'b0;
        bus.req_chunk_ptr_rst = 1'b0;
        bus.rd_release        = 1'b0;

        do_reset();
        check_reset_state("reset");

        // Single vector 0..15, readiness only after the last element.
        write_run(0, 15);
        check_output("odr_before_last", 32'(bus.out_data_ready), 32'd0);
        write_run(15, 1);
        check_output("odr_after_fill", 32'(bus.out_data_ready), 32'd1);
        check_output("chunk0", bus.out_data, exp_chunk(0));
        check_output("fc_one", 32'(dut.full_count), 32'd1);

        pulse_req();
        check_output("chunk1", bus.out_data, exp_chunk(4));
        check_output("idx1", 32'(bus.rd_chunk_idx), 32'd1);
        pulse_req();
        check_output("chunk2", bus.out_data, exp_chunk(8));
        pulse_req();
        check_output("chunk3", bus.out_data, exp_chunk(12));
        check_output("idx3", 32'(bus.rd_chunk_idx), 32'd3);
        pulse_req();
        check_output("chunk_wrap", bus.out_data, exp_chunk(0));
        check_output("idx_wrap", 32'(bus.rd_chunk_idx), 32'd0);

        // Pointer rewind wins over advance.
        pulse_req();
        pulse_req();
        check_output("mid_chunk2", bus.out_data, exp_chunk(8));
        bus.req_chunk_ptr_rst = 1'b1;
        bus.req_chunk_in      = 1'b1;
        tick();
        bus.req_chunk_ptr_rst = 1'b0;
        bus.req_chunk_in      = 1'b0;
        check_output("rewind_chunk", bus.out_data, exp_chunk(0));
        check_output("rewind_idx", 32'(bus.rd_chunk_idx), 32'd0);
        check_output("rewind_fc", 32'(dut.full_count), 32'd1);

        // Second vector fills the other bank; extra writes overflow.
        write_run(100, 16);
        check_output("both_full_ready", 32'(bus.wr_ready), 32'd0);
        check_output("both_full_fc", 32'(dut.full_count), 32'd2);
        check_output("a_still_read", bus.out_data, exp_chunk(0));
        write_run(50, 3);
        check_output("overflow_set", 32'(bus.overflow), 32'd1);
        check_output("overflow_ready", 32'(bus.wr_ready), 32'd0);
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        check_output("b_chunk0", bus.out_data, exp_chunk(100));
        check_output("after_release_ready", 32'(bus.wr_ready), 32'd1);
        check_output("after_release_fc", 32'(dut.full_count), 32'd1);
        check_output("overflow_sticky", 32'(bus.overflow), 32'd1);
        pulse_req();
        pulse_req();
        pulse_req();
        check_output("b_chunk3", bus.out_data, exp_chunk(112));

        // Last element of B lands in the same cycle A is released.
        do_reset();
        write_run(0, 16);
        write_run(100, 15);
        check_output("pre_sim_fc", 32'(dut.full_count), 32'd1);
        bus.wr_en      = 1'b1;
        bus.wr_data    = 8'(115);
        bus.rd_release = 1'b1;
        tick();
        bus.wr_en      = 1'b0;
        bus.rd_release = 1'b0;
        check_output("sim_fc", 32'(dut.full_count), 32'd1);
        check_output("sim_chunk0", bus.out_data, exp_chunk(100));
        check_output("sim_ready", 32'(bus.wr_ready), 32'd1);
        check_output("sim_overflow", 32'(bus.overflow), 32'd0);
        pulse_req();
        pulse_req();
        pulse_req();
        check_output("sim_chunk3", bus.out_data, exp_chunk(112));

        // Reset mid-fill discards everything.
        do_reset();
        write_run(0, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midfill_reset");

        // Read-side inputs with nothing stored must not move anything.
        bus.req_chunk_in = 1'b1;
        bus.rd_release   = 1'b1;
        tick();
        bus.req_chunk_in = 1'b0;
        bus.rd_release   = 1'b0;
        check_output("empty_idx", 32'(bus.rd_chunk_idx), 32'd0);
        check_output("empty_fc", 32'(dut.full_count), 32'd0);

        // Fresh vector with signed values -8..7.
        write_run(-8, 16);
        check_output("fresh_odr", 32'(bus.out_data_ready), 32'd1);
        check_output("fresh_chunk0", bus.out_data, exp_chunk(-8));
        pulse_req();
        check_output("fresh_chunk1", bus.out_data, exp_chunk(-4));
        pulse_req();
        check_output("fresh_chunk2", bus.out_data, exp_chunk(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
